// File: rtl/spram_loader_pkg.sv
// spram_loader_pkg: loader FSM states and address-range helpers
package spram_loader_pkg;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_FILL, LD_DONE} ld_state_t;
  localparam int LD_ADDR_WIDTH = 8;
  localparam int LD_DATA_WIDTH = 8;
  function automatic int ld_max_addr(input int aw);
    return (1 << aw) - 1;
  endfunction
endpackage

// File: rtl/spram_loader.sv
// spram_loader: streams a download image into spram, pads the tail, then returns the port to the CPU (checksum output with SPRAM_LOADER_CHECKSUM_EN)
module spram_loader
  import spram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LD_ADDR_WIDTH,
  parameter int DATA_WIDTH = LD_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dl_start,
  input  logic                  dl_valid,
  input  logic [DATA_WIDTH-1:0] dl_data,
  input  logic                  dl_last,
  output logic                  dl_ready,
  input  logic                  cpu_cs,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic                  cpu_stall,
  output logic                  ram_cs,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  done,
  output logic                  overflow
`ifdef SPRAM_LOADER_CHECKSUM_EN
  ,output logic [DATA_WIDTH-1:0] checksum
`endif
);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(ld_max_addr(ADDR_WIDTH));
  ld_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic wr_pend, start, xfer, at_top, wr_load, wr_fill, owner;
  // next state, port ownership and the RAM/CPU mux
  always_comb begin
    start = dl_start && (state == LD_IDLE || state == LD_DONE);
    dl_ready = state == LD_LOAD || state == LD_DONE;
    xfer = dl_valid && dl_ready;
    at_top = ptr == MAX_ADDR;
    wr_load = state == LD_LOAD && xfer;
    wr_fill = state == LD_FILL;
    state_nxt = state;
    if (start) state_nxt = LD_LOAD;
    else if (wr_load && (at_top || dl_last)) state_nxt = at_top ? LD_DONE : LD_FILL;
    else if (wr_fill && at_top) state_nxt = LD_DONE;
    owner = state == LD_LOAD || state == LD_FILL || wr_pend;
    done = state == LD_DONE && !wr_pend;
    cpu_stall = owner;
    ram_cs = owner ? 1'b1 : cpu_cs;
    ram_wren = owner ? wr_pend : cpu_we;
    ram_addr = owner ? wr_addr : cpu_addr;
    ram_data = owner ? wr_data : cpu_din;
  end
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= LD_IDLE;
    else state <= state_nxt;
  // pointer, one-deep write register and sticky overflow
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ptr <= '0;
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      overflow <= 1'b0;
    end else begin
      wr_pend <= wr_load || wr_fill;
      if (wr_load || wr_fill) begin
        wr_addr <= ptr;
        wr_data <= wr_load ? dl_data : PAD_VALUE;
      end
      ptr <= start ? '0 : (wr_load || wr_fill) ? ptr + ADDR_WIDTH'(1) : ptr;
      overflow <= start ? 1'b0 : (state == LD_DONE && xfer) ? 1'b1 : overflow;
    end
`ifdef SPRAM_LOADER_CHECKSUM_EN
  // running modular sum of image beats only
  always_ff @(posedge clock or posedge reset)
    if (reset) checksum <= '0;
    else checksum <= start ? '0 : wr_load ? checksum + dl_data : checksum;
`endif
endmodule
